// File: rtl/fetch_queue.sv
// FWFT {pc, inst} queue between IFU and IDU; push to head visible 1 cycle later, no input->output bypass.
// Backpressure: ready_o/valid_o come from registered count only; a full queue does not accept while popping.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       flush_i,
   input  logic [XLEN-1:0]            pc_i,
   input  logic [XLEN-1:0]            inst_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [XLEN-1:0]            inst_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] r_mem_pc   [DEPTH];
   logic [XLEN-1:0] r_mem_inst [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_pc_o;
   logic [XLEN-1:0] r_inst_o;

   logic            w_push;
   logic            w_pop;
   logic [AW-1:0]   w_rd_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_fwd;

   assign ready_o  = (r_count != CW'(DEPTH));
   assign valid_o  = (r_count != '0);
   assign count_o  = r_count;
   assign pc_o     = r_pc_o;
   assign inst_o   = r_inst_o;

   assign w_push   = valid_i & ready_o;
   assign w_pop    = valid_o & ready_i;
   assign w_rd_nxt = r_rd_ptr + AW'(w_pop);
   // The slot becoming head is being written this cycle: take the input instead of stale storage.
   assign w_fwd    = w_push && (r_wr_ptr == w_rd_nxt);

   always_comb begin
      w_cnt_nxt = r_count;
      if (flush_i) begin
         w_cnt_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_cnt_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_cnt_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) begin
         r_mem_pc[r_wr_ptr]   <= pc_i;
         r_mem_inst[r_wr_ptr] <= inst_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_pc_o   <= '0;
         r_inst_o <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_cnt_nxt;
         // Head registers hold their last value while the queue is empty.
         if (w_cnt_nxt != '0) begin
            r_pc_o   <= w_fwd ? pc_i   : r_mem_pc[w_rd_nxt];
            r_inst_o <= w_fwd ? inst_i : r_mem_inst[w_rd_nxt];
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: async reset, single push/pop, fill/drain, full+pop, streaming, flush.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            flush_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] inst_i;
   logic            valid_i;
   logic            ready_o;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] inst_o;
   logic            valid_o;
   logic            ready_i;
   logic [2:0]      count_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .pc_i    (pc_i),
      .inst_i  (inst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .pc_o    (pc_o),
      .inst_o  (inst_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .count_o (count_o)
   );

   typedef struct {
      logic        flush;
      logic        valid;
      logic [31:0] pc;
      logic        rdy;
      logic        e_ready;
      logic        e_valid;
      logic [2:0]  e_cnt;
      logic        chk_pc;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl [24];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], 16'h0013};
   endfunction

   function automatic vec_t mk(input logic fl, input logic v, input logic [31:0] pc, input logic r,
                               input logic er, input logic ev, input logic [2:0] ec,
                               input logic cp, input logic [31:0] ep);
      vec_t t;
      t.flush = fl; t.valid = v; t.pc = pc; t.rdy = r;
      t.e_ready = er; t.e_valid = ev; t.e_cnt = ec; t.chk_pc = cp; t.e_pc = ep;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic v, input logic [31:0] pc, input logic r);
      flush_i = fl;
      valid_i = v;
      pc_i    = pc;
      inst_i  = inst_of(pc);
      ready_i = r;
   endtask

   initial begin
      // Rows: inputs applied at this negedge; expectations are the outputs seen at the same negedge.
      tbl[0]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0);
      tbl[1]  = mk(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, 32'h0);
      tbl[2]  = mk(0, 0, 32'h0,         1, 1, 1, 1, 1, 32'h8000_0000);
      tbl[3]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0);
      tbl[4]  = mk(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, 32'h0);
      tbl[5]  = mk(0, 1, 32'h8000_0004, 0, 1, 1, 1, 1, 32'h8000_0000);
      tbl[6]  = mk(0, 1, 32'h8000_0008, 0, 1, 1, 2, 1, 32'h8000_0000);
      tbl[7]  = mk(0, 1, 32'h8000_000C, 0, 1, 1, 3, 1, 32'h8000_0000);
      tbl[8]  = mk(0, 1, 32'h8000_0010, 0, 0, 1, 4, 1, 32'h8000_0000);
      tbl[9]  = mk(0, 1, 32'h8000_0010, 0, 0, 1, 4, 1, 32'h8000_0000);
      tbl[10] = mk(0, 1, 32'h8000_0010, 1, 0, 1, 4, 1, 32'h8000_0000);
      tbl[11] = mk(0, 1, 32'h8000_0010, 1, 1, 1, 3, 1, 32'h8000_0004);
      tbl[12] = mk(0, 0, 32'h0,         1, 1, 1, 3, 1, 32'h8000_0008);
      tbl[13] = mk(0, 0, 32'h0,         1, 1, 1, 2, 1, 32'h8000_000C);
      tbl[14] = mk(0, 0, 32'h0,         1, 1, 1, 1, 1, 32'h8000_0010);
      tbl[15] = mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0);
      tbl[16] = mk(0, 1, 32'h8000_0200, 0, 1, 0, 0, 0, 32'h0);
      tbl[17] = mk(0, 1, 32'h8000_0204, 0, 1, 1, 1, 1, 32'h8000_0200);
      tbl[18] = mk(0, 1, 32'h8000_0208, 0, 1, 1, 2, 1, 32'h8000_0200);
      tbl[19] = mk(1, 1, 32'h8000_020C, 1, 1, 1, 3, 1, 32'h8000_0200);
      tbl[20] = mk(0, 1, 32'h8000_0100, 0, 1, 0, 0, 0, 32'h0);
      tbl[21] = mk(0, 0, 32'h0,         0, 1, 1, 1, 1, 32'h8000_0100);
      tbl[22] = mk(0, 0, 32'h0,         1, 1, 1, 1, 1, 32'h8000_0100);
      tbl[23] = mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0);

      rst_n_i = 1'b0;
      drive(0, 0, 32'h0, 0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;

      // Asynchronous reset in the middle of traffic.
      @(negedge clk_i);
      drive(0, 1, 32'h8000_0040, 0);
      @(negedge clk_i);
      drive(0, 1, 32'h8000_0044, 0);
      @(negedge clk_i);
      chk("pre_reset_count", 32'(count_o), 32'd2);
      @(posedge clk_i);
      #2 rst_n_i = 1'b0;
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_pc",    pc_o,         32'h0);
      chk("rst_inst",  inst_o,       32'h0);
      drive(0, 0, 32'h0, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk_i);
         chk($sformatf("row%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_ready));
         chk($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
         chk($sformatf("row%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
         if (tbl[i].chk_pc) begin
            chk($sformatf("row%0d_pc", i),   pc_o,   tbl[i].e_pc);
            chk($sformatf("row%0d_inst", i), inst_o, inst_of(tbl[i].e_pc));
         end
         drive(tbl[i].flush, tbl[i].valid, tbl[i].pc, tbl[i].rdy);
      end

      // Streaming through pointer wrap: one in, one out per cycle.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (k == 0) begin
            chk("stream_start_valid", 32'(valid_o), 32'd0);
         end else begin
            chk($sformatf("stream%0d_count", k), 32'(count_o), 32'd1);
            chk($sformatf("stream%0d_ready", k), 32'(ready_o), 32'd1);
            chk($sformatf("stream%0d_pc", k),    pc_o, 32'h8000_1000 + 32'(4 * (k - 1)));
         end
         drive(0, 1, 32'h8000_1000 + 32'(4 * k), 1);
      end
      @(negedge clk_i);
      chk("stream_last_pc",    pc_o,   32'h8000_1000 + 32'(4 * 19));
      chk("stream_last_inst",  inst_o, inst_of(32'h8000_1000 + 32'(4 * 19)));
      drive(0, 0, 32'h0, 1);
      @(negedge clk_i);
      chk("stream_end_count", 32'(count_o), 32'd0);
      chk("stream_end_valid", 32'(valid_o), 32'd0);
      drive(0, 0, 32'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
